// File: rtl/divider_sched_pkg.sv
// Shared types and helpers for the divider scheduler.
// Optional divide-by-zero bypass is enabled by defining DIVIDER_SCHED_DZ_BYPASS_EN.
package divider_sched_pkg;

    // Tag fields are sized for the largest supported configuration.
    localparam int MAX_ID_W = 4;
    localparam int MAX_DW   = 32;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int slice_lsb(input int idx, input int w);
        return idx * w;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
        logic                dz;
        logic [MAX_DW-1:0]   a;
`endif
    } sched_tag_t;

endpackage

// File: rtl/divider_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after rr_ptr wins.
module divider_sched_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && eligible[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
                grant_any                                       = 1'b1;
                grant[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]      = 1'b1;
                grant_idx                                       = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/divider_sched.sv
// Round-robin scheduler sharing one pipelined divider among NUM_REQ requesters.
// Define DIVIDER_SCHED_DZ_BYPASS_EN to answer b==0 locally instead of issuing it.
module divider_sched
    import divider_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATAWIDTH   = 8,
    parameter int FRAC_BITS   = 0,
    parameter int DIV_LATENCY = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATAWIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [NUM_REQ*DATAWIDTH-1:0]   rsp_q,
    output logic [NUM_REQ*DATAWIDTH-1:0]   rsp_r,
    output logic [NUM_REQ-1:0]             rsp_dz,
    output logic                           div_i_valid,
    output logic [DATAWIDTH-1:0]           div_a,
    output logic [DATAWIDTH-1:0]           div_b,
    input  logic                           div_o_valid,
    input  logic [DATAWIDTH-1:0]           div_q,
    input  logic [DATAWIDTH-1:0]           div_r,
    output logic                           err_tag_mismatch
);

    localparam int ID_W = id_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("divider_sched: NUM_REQ out of range");
    end
    if (DIV_LATENCY < 1) begin : g_bad_latency
        $error("divider_sched: DIV_LATENCY must be >= 1");
    end
    if (DATAWIDTH < 1 || DATAWIDTH > MAX_DW || FRAC_BITS < 0 || FRAC_BITS > DATAWIDTH) begin : g_bad_width
        $error("divider_sched: bad DATAWIDTH/FRAC_BITS");
    end

    logic [NUM_REQ-1:0]   busy_q, busy_d, rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0]   eligible, grant, hs;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d, grant_idx;
    logic                 grant_any, err_q, err_d, ret_div, exp_ov;
    logic [DATAWIDTH-1:0] quo_q [NUM_REQ];
    logic [DATAWIDTH-1:0] quo_d [NUM_REQ];
    logic [DATAWIDTH-1:0] rem_q [NUM_REQ];
    logic [DATAWIDTH-1:0] rem_d [NUM_REQ];
    logic [DATAWIDTH-1:0] gnt_a, gnt_b;
    sched_tag_t           tag_q [DIV_LATENCY];
    sched_tag_t           tag_d [DIV_LATENCY];
    sched_tag_t           tag_in, tag_out;
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
    logic [NUM_REQ-1:0]   rsp_dz_q, rsp_dz_d;
    logic                 gnt_dz, ret_dz;
`endif

    // Grants are suppressed while rst is high so nothing is accepted into a clearing pipe.
    assign eligible = req_valid & ~busy_q & {NUM_REQ{~rst}};

    divider_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign tag_out   = tag_q[DIV_LATENCY-1];
    assign hs        = rsp_valid_q & rsp_ready;

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_a = req_a[slice_lsb(i, DATAWIDTH) +: DATAWIDTH];
                gnt_b = req_b[slice_lsb(i, DATAWIDTH) +: DATAWIDTH];
            end
        end
    end

`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
    assign gnt_dz      = grant_any && (gnt_b == '0);
    assign div_i_valid = grant_any && !gnt_dz;
    assign div_a       = div_i_valid ? gnt_a : '0;
    assign div_b       = div_i_valid ? gnt_b : '0;
    assign ret_dz      = tag_out.valid && tag_out.dz;
    assign exp_ov      = tag_out.valid && !tag_out.dz;
    assign rsp_dz      = rsp_dz_q;
`else
    assign div_i_valid = grant_any;
    assign div_a       = gnt_a;
    assign div_b       = gnt_b;
    assign exp_ov      = tag_out.valid;
    assign rsp_dz      = '0;
`endif
    assign ret_div = exp_ov && div_o_valid;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = grant_any;
        tag_in.id    = MAX_ID_W'(grant_idx);
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
        tag_in.dz    = gnt_dz;
        tag_in.a     = MAX_DW'(gnt_a);
`endif
        tag_d[0] = tag_in;
        for (int k = 1; k < DIV_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    always_comb begin
        busy_d      = (busy_q & ~hs) | grant;
        rsp_valid_d = rsp_valid_q & ~hs;
        quo_d       = quo_q;
        rem_d       = rem_q;
        err_d       = err_q || (div_o_valid != exp_ov);
        rr_ptr_d    = rr_ptr_q;
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
        rsp_dz_d    = rsp_dz_q;
`endif
        if (grant_any) begin
            rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
        // A divider result without a matching tag has no owner and is dropped.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_out.id == MAX_ID_W'(i)) begin
                if (ret_div) begin
                    rsp_valid_d[i] = 1'b1;
                    quo_d[i]       = div_q;
                    rem_d[i]       = div_r;
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
                    rsp_dz_d[i]    = 1'b0;
`endif
                end
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
                if (ret_dz) begin
                    rsp_valid_d[i] = 1'b1;
                    quo_d[i]       = '1;
                    rem_d[i]       = tag_out.a[DATAWIDTH-1:0];
                    rsp_dz_d[i]    = 1'b1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rr_ptr_q    <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < DIV_LATENCY; k++) tag_q[k] <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                quo_q[i] <= '0;
                rem_q[i] <= '0;
            end
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
            rsp_dz_q    <= '0;
`endif
        end else begin
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            err_q       <= err_d;
            tag_q       <= tag_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
            rsp_dz_q    <= rsp_dz_d;
`endif
        end
    end

    always_comb begin
        rsp_q = '0;
        rsp_r = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_q[slice_lsb(i, DATAWIDTH) +: DATAWIDTH] = quo_q[i];
            rsp_r[slice_lsb(i, DATAWIDTH) +: DATAWIDTH] = rem_q[i];
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign err_tag_mismatch = err_q;

endmodule

// File: tb/tb_divider_sched.sv
// Bench for divider_sched with a 2-cycle behavioural divider and a transaction-level reference model.
module tb_divider_sched;
    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ready, rsp_valid, rsp_ready, rsp_dz;
    logic [NR*DW-1:0] req_a, req_b, rsp_q, rsp_r;
    logic             div_i_valid, div_o_valid, err_tag_mismatch;
    logic [DW-1:0]    div_a, div_b, div_q, div_r;
    int               pass_cnt = 0;
    int               total_cnt = 0;

    // Behavioural divider: two register stages, restoring-array result for b==0.
    logic          s1_v, s2_v, spur;
    logic [DW-1:0] s1_a, s1_b, s2_a, s2_b;
    always @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= div_i_valid;
            s2_v <= s1_v;
        end
        s1_a <= div_a;
        s1_b <= div_b;
        s2_a <= s1_a;
        s2_b <= s1_b;
    end
    assign div_o_valid = s2_v | spur;
    assign div_q = (s2_b == 0) ? 8'hFF : s2_a / s2_b;
    assign div_r = (s2_b == 0) ? s2_a : s2_a % s2_b;

    divider_sched #(
        .NUM_REQ     (NR),
        .DATAWIDTH   (DW),
        .FRAC_BITS   (0),
        .DIV_LATENCY (LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_q            (rsp_q),
        .rsp_r            (rsp_r),
        .rsp_dz           (rsp_dz),
        .div_i_valid      (div_i_valid),
        .div_a            (div_a),
        .div_b            (div_b),
        .div_o_valid      (div_o_valid),
        .div_q            (div_q),
        .div_r            (div_r),
        .err_tag_mismatch (err_tag_mismatch)
    );

    function automatic logic [DW-1:0] get_q(input int i);
        return rsp_q[i*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] get_r(input int i);
        return rsp_r[i*DW +: DW];
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        spur = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        total_cnt++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready got=%b exp=0000", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 4'b0) $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); else pass_cnt++;
        total_cnt++; if (div_i_valid !== 1'b0) $display("FAIL reset_div_i_valid got=%b exp=0", div_i_valid); else pass_cnt++;
        total_cnt++; if (err_tag_mismatch !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_tag_mismatch); else pass_cnt++;
        total_cnt++; if (rsp_q !== '0 || rsp_r !== '0) $display("FAIL reset_rsp_data got q=%h r=%h exp=0", rsp_q, rsp_r); else pass_cnt++;
        total_cnt++; if (rsp_dz !== 4'b0) $display("FAIL reset_rsp_dz got=%b exp=0000", rsp_dz); else pass_cnt++;
    endtask

    task automatic test_single;
        do_reset;
        req_valid = 4'b0001;
        set_op(0, 100, 7);
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", req_ready); else pass_cnt++;
        total_cnt++; if (div_i_valid !== 1'b1 || div_a !== 8'd100 || div_b !== 8'd7) $display("FAIL single_issue got v=%b a=%0d b=%0d exp v=1 a=100 b=7", div_i_valid, div_a, div_b); else pass_cnt++;
        tick;
        req_valid = 4'b0000;
        #1;
        total_cnt++; if (rsp_valid !== 4'b0) $display("FAIL single_early_c1 got=%b exp=0000", rsp_valid); else pass_cnt++;
        tick;
        total_cnt++; if (rsp_valid !== 4'b0) $display("FAIL single_early_c2 got=%b exp=0000", rsp_valid); else pass_cnt++;
        tick;
        req_valid = 4'b0001;
        #1;
        total_cnt++; if (rsp_valid !== 4'b0001 || get_q(0) !== 8'd14 || get_r(0) !== 8'd2) $display("FAIL single_result got v=%b q=%0d r=%0d exp v=0001 q=14 r=2", rsp_valid, get_q(0), get_r(0)); else pass_cnt++;
        total_cnt++; if (req_ready !== 4'b0) $display("FAIL single_busy_ready got=%b exp=0000", req_ready); else pass_cnt++;
        for (int h = 0; h < 4; h++) begin
            tick;
            total_cnt++; if (rsp_valid !== 4'b0001 || get_q(0) !== 8'd14 || get_r(0) !== 8'd2 || req_ready !== 4'b0) $display("FAIL single_hold%0d got v=%b q=%0d r=%0d rdy=%b exp v=0001 q=14 r=2 rdy=0000", h, rsp_valid, get_q(0), get_r(0), req_ready); else pass_cnt++;
        end
        rsp_ready = 4'b0001;
        tick;
        rsp_ready = 4'b0000;
        #1;
        total_cnt++; if (rsp_valid !== 4'b0 || req_ready !== 4'b0001) $display("FAIL single_after_hs got v=%b rdy=%b exp v=0000 rdy=0001", rsp_valid, req_ready); else pass_cnt++;
    endtask

    task automatic test_fairness;
        int fa [NR];
        int fb [NR];
        int id;
        logic [NR-1:0] e;
        do_reset;
        for (int i = 0; i < NR; i++) begin
            fa[i] = int'($urandom_range(1, 255));
            fb[i] = int'($urandom_range(1, 15));
            set_op(i, fa[i], fb[i]);
        end
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            #1;
            e = 4'b0001 << (c % NR);
            total_cnt++; if (req_ready !== e) $display("FAIL fair_grant c%0d got=%b exp=%b", c, req_ready, e); else pass_cnt++;
            if (c >= 3) begin
                id = (c - 3) % NR;
                e = 4'b0001 << id;
                total_cnt++; if (rsp_valid !== e || get_q(id) !== DW'(fa[id] / fb[id]) || get_r(id) !== DW'(fa[id] % fb[id])) $display("FAIL fair_rsp c%0d got v=%b q=%0d r=%0d exp v=%b q=%0d r=%0d", c, rsp_valid, get_q(id), get_r(id), e, fa[id] / fb[id], fa[id] % fb[id]); else pass_cnt++;
            end
            tick;
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        req_valid = 4'b0100;
        set_op(2, 9, 4);
        #1;
        total_cnt++; if (req_ready !== 4'b0100) $display("FAIL bp_grant got=%b exp=0100", req_ready); else pass_cnt++;
        tick;
        tick;
        tick;
        for (int h = 0; h < 10; h++) begin
            total_cnt++; if (rsp_valid !== 4'b0100 || get_q(2) !== 8'd2 || get_r(2) !== 8'd1 || req_ready !== 4'b0) $display("FAIL bp_hold%0d got v=%b q=%0d r=%0d rdy=%b exp v=0100 q=2 r=1 rdy=0000", h, rsp_valid, get_q(2), get_r(2), req_ready); else pass_cnt++;
            tick;
        end
        rsp_ready = 4'b0100;
        #1;
        total_cnt++; if (req_ready !== 4'b0) $display("FAIL bp_hs_cycle_ready got=%b exp=0000", req_ready); else pass_cnt++;
        tick;
        rsp_ready = 4'b0000;
        #1;
        total_cnt++; if (rsp_valid !== 4'b0 || req_ready !== 4'b0100) $display("FAIL bp_after_hs got v=%b rdy=%b exp v=0000 rdy=0100", rsp_valid, req_ready); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int a1, b1, a3, b3;
        a1 = int'($urandom_range(0, 255));
        b1 = int'($urandom_range(1, 255));
        a3 = int'($urandom_range(0, 255));
        b3 = int'($urandom_range(1, 255));
        do_reset;
        rsp_ready = 4'b1111;
        set_op(1, a1, b1);
        set_op(3, a3, b3);
        req_valid = 4'b0010;
        #1;
        total_cnt++; if (req_ready !== 4'b0010 || div_i_valid !== 1'b1 || div_a !== DW'(a1)) $display("FAIL b2b_issue1 got rdy=%b v=%b a=%0d exp rdy=0010 v=1 a=%0d", req_ready, div_i_valid, div_a, a1); else pass_cnt++;
        tick;
        req_valid = 4'b1000;
        #1;
        total_cnt++; if (req_ready !== 4'b1000 || div_i_valid !== 1'b1 || div_a !== DW'(a3) || div_b !== DW'(b3)) $display("FAIL b2b_issue2 got rdy=%b v=%b a=%0d b=%0d exp rdy=1000 v=1 a=%0d b=%0d", req_ready, div_i_valid, div_a, div_b, a3, b3); else pass_cnt++;
        tick;
        req_valid = 4'b0000;
        tick;
        total_cnt++; if (rsp_valid !== 4'b0010 || get_q(1) !== DW'(a1 / b1) || get_r(1) !== DW'(a1 % b1)) $display("FAIL b2b_rsp1 got v=%b q=%0d r=%0d exp v=0010 q=%0d r=%0d", rsp_valid, get_q(1), get_r(1), a1 / b1, a1 % b1); else pass_cnt++;
        tick;
        total_cnt++; if (rsp_valid !== 4'b1000 || get_q(3) !== DW'(a3 / b3) || get_r(3) !== DW'(a3 % b3)) $display("FAIL b2b_rsp3 got v=%b q=%0d r=%0d exp v=1000 q=%0d r=%0d", rsp_valid, get_q(3), get_r(3), a3 / b3, a3 % b3); else pass_cnt++;
    endtask

    task automatic test_reset_midflight;
        do_reset;
        req_valid = 4'b0001;
        set_op(0, 200, 3);
        tick;
        req_valid = 4'b0000;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            total_cnt++; if (rsp_valid !== 4'b0 || err_tag_mismatch !== 1'b0) $display("FAIL midrst_c%0d got v=%b err=%b exp v=0000 err=0", c, rsp_valid, err_tag_mismatch); else pass_cnt++;
            tick;
        end
        req_valid = 4'b1111;
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL midrst_ptr got=%b exp=0001", req_ready); else pass_cnt++;
    endtask

    task automatic test_div_zero;
        do_reset;
        req_valid = 4'b0001;
        set_op(0, 55, 0);
        #1;
        total_cnt++; if (req_ready !== 4'b0001) $display("FAIL dz_ready got=%b exp=0001", req_ready); else pass_cnt++;
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
        total_cnt++; if (div_i_valid !== 1'b0) $display("FAIL dz_issue got=%b exp=0", div_i_valid); else pass_cnt++;
`else
        total_cnt++; if (div_i_valid !== 1'b1) $display("FAIL dz_issue got=%b exp=1", div_i_valid); else pass_cnt++;
`endif
        tick;
        req_valid = 4'b0000;
        tick;
        tick;
        total_cnt++; if (rsp_valid !== 4'b0001 || get_q(0) !== 8'd255 || get_r(0) !== 8'd55) $display("FAIL dz_result got v=%b q=%0d r=%0d exp v=0001 q=255 r=55", rsp_valid, get_q(0), get_r(0)); else pass_cnt++;
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
        total_cnt++; if (rsp_dz !== 4'b0001) $display("FAIL dz_flag got=%b exp=0001", rsp_dz); else pass_cnt++;
`else
        total_cnt++; if (rsp_dz !== 4'b0000) $display("FAIL dz_flag got=%b exp=0000", rsp_dz); else pass_cnt++;
`endif
        total_cnt++; if (err_tag_mismatch !== 1'b0) $display("FAIL dz_err got=%b exp=0", err_tag_mismatch); else pass_cnt++;
    endtask

    task automatic test_tag_err;
        do_reset;
        spur = 1'b1;
        tick;
        spur = 1'b0;
        total_cnt++; if (err_tag_mismatch !== 1'b1 || rsp_valid !== 4'b0) $display("FAIL tagerr_set got err=%b v=%b exp err=1 v=0000", err_tag_mismatch, rsp_valid); else pass_cnt++;
        for (int c = 0; c < 5; c++) tick;
        total_cnt++; if (err_tag_mismatch !== 1'b1) $display("FAIL tagerr_sticky got=%b exp=1", err_tag_mismatch); else pass_cnt++;
    endtask

    typedef struct {
        int id;
        int a;
        int b;
        int due;
    } op_t;

    task automatic test_random;
        op_t           inflight[$];
        op_t           op;
        logic [NR-1:0] m_busy, m_rv, m_dz, exp_ready;
        int            m_q [NR];
        int            m_r [NR];
        int            m_ptr, g, idx, ga, gb;
        logic          exp_iv;
        do_reset;
        m_busy = '0;
        m_rv = '0;
        m_dz = '0;
        m_ptr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            while (inflight.size() > 0 && inflight[0].due == cyc) begin
                op = inflight.pop_front();
                m_rv[op.id] = 1'b1;
                m_q[op.id] = (op.b == 0) ? 255 : op.a / op.b;
                m_r[op.id] = (op.b == 0) ? op.a : op.a % op.b;
                m_dz[op.id] = (op.b == 0);
            end
            for (int i = 0; i < NR; i++) begin
                req_valid[i] = ($urandom_range(0, 3) != 0);
                rsp_ready[i] = ($urandom_range(0, 2) != 0);
                set_op(i, int'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)));
            end
            #1;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                idx = (m_ptr + k) % NR;
                if (g < 0 && req_valid[idx] && !m_busy[idx]) g = idx;
            end
            exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            ga = (g >= 0) ? int'(req_a[g*DW +: DW]) : 0;
            gb = (g >= 0) ? int'(req_b[g*DW +: DW]) : 0;
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
            exp_iv = (g >= 0) && (gb != 0);
`else
            exp_iv = (g >= 0);
`endif
            total_cnt++; if (req_ready !== exp_ready || div_i_valid !== exp_iv) $display("FAIL rand_grant c%0d got rdy=%b iv=%b exp rdy=%b iv=%b", cyc, req_ready, div_i_valid, exp_ready, exp_iv); else pass_cnt++;
            total_cnt++; if (rsp_valid !== m_rv) $display("FAIL rand_rsp_valid c%0d got=%b exp=%b", cyc, rsp_valid, m_rv); else pass_cnt++;
            for (int i = 0; i < NR; i++) begin
                if (m_rv[i]) begin
                    total_cnt++; if (get_q(i) !== DW'(m_q[i]) || get_r(i) !== DW'(m_r[i])) $display("FAIL rand_data c%0d id%0d got q=%0d r=%0d exp q=%0d r=%0d", cyc, i, get_q(i), get_r(i), m_q[i], m_r[i]); else pass_cnt++;
`ifdef DIVIDER_SCHED_DZ_BYPASS_EN
                    total_cnt++; if (rsp_dz[i] !== m_dz[i]) $display("FAIL rand_dz c%0d id%0d got=%b exp=%b", cyc, i, rsp_dz[i], m_dz[i]); else pass_cnt++;
`endif
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (m_rv[i] && rsp_ready[i]) begin
                    m_rv[i] = 1'b0;
                    m_busy[i] = 1'b0;
                end
            end
            if (g >= 0) begin
                m_busy[g] = 1'b1;
                op.id = g;
                op.a = ga;
                op.b = gb;
                op.due = cyc + LAT + 1;
                inflight.push_back(op);
                m_ptr = (g + 1) % NR;
            end
            tick;
        end
        total_cnt++; if (err_tag_mismatch !== 1'b0) $display("FAIL rand_err got=%b exp=0", err_tag_mismatch); else pass_cnt++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        rsp_ready = '0;
        req_a = '0;
        req_b = '0;
        spur = 1'b0;
        test_reset;
        test_single;
        test_fairness;
        test_backpressure;
        test_back_to_back;
        test_reset_midflight;
        test_div_zero;
        test_tag_err;
        test_random;
        test_reset;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
